regfile_wb: RTL and testbench

//  Write-back end of the operand path: 32-entry integer register file that feeds rrdata1/rrdata2
//  to the ALU-input muxes and accepts results from the write-back select.

---
 rtl/regfile_wb_if.sv | 37 +++
 rtl/regfile_wb.sv | 136 +++++++++++++
 tb/tb_regfile_wb.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_if.sv
// Operand/write-back bus of the register file.
// master drives read addrs, wb inputs, load events; slave returns data, stall.
interface regfile_wb_if #(
  parameter int XLEN = 32
);
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] rrdata1;
  logic [XLEN-1:0] rrdata2;
  logic [4:0]      rd;
  logic            we;
  logic [1:0]      wb_sel;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc;
  logic            load_issue;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_rvalid;
  logic            load_pending;
  logic            stall;

  modport master (
    output rs1, rs2, rd, we, wb_sel,
    output alu_out, imm, pc,
    output load_issue, dmem_rdata, dmem_rvalid,
    input  rrdata1, rrdata2,
    input  load_pending, stall
  );

  modport slave (
    input  rs1, rs2, rd, we, wb_sel,
    input  alu_out, imm, pc,
    input  load_issue, dmem_rdata, dmem_rvalid,
    output rrdata1, rrdata2,
    output load_pending, stall
  );
endinterface

// File: rtl/regfile_wb.sv
// 32x XLEN register file with write-back select, one outstanding load, hazard stall.
// Ports: clk, reset (sync, active-high), bus (regfile_wb_if.slave).
// Option: RF_LOAD_BYPASS_EN forwards dmem_rdata to readers in the return cycle.
module regfile_wb #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VAL = '0
) (
  input logic         clk,
  input logic         reset,
  regfile_wb_if.slave bus
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [4:0]      r_pend_rd;
  logic [4:0]      w_pend_rd_nxt;
  logic [XLEN-1:0] r_regs [32];

  logic            w_pend;
  logic            w_hz;
  logic            w_hz_read;
  logic            w_stall;
  logic            w_we_ok;
  logic            w_ld_ok;
  logic            w_ld_commit;
  logic [XLEN-1:0] w_wb_data;

  assign w_pend = (r_state == S_WAIT);

  assign w_hz = w_pend &&
    ((bus.rs1 == r_pend_rd) ||
     (bus.rs2 == r_pend_rd));

`ifdef RF_LOAD_BYPASS_EN
  assign w_hz_read = w_hz && !bus.dmem_rvalid;
`else
  assign w_hz_read = w_hz;
`endif

  // A new load or a WAW write must wait until the pending return lands.
  assign w_stall =
    (w_pend && !bus.dmem_rvalid &&
     (bus.load_issue ||
      (bus.we && bus.rd == r_pend_rd))) ||
    w_hz_read;

  assign w_we_ok = bus.we && !w_stall &&
    (bus.rd != 5'd0) && (bus.wb_sel != 2'b11);

  assign w_ld_ok = bus.load_issue && !w_stall &&
    (bus.rd != 5'd0);

  assign w_ld_commit = w_pend && bus.dmem_rvalid;

  always_comb begin
    w_wb_data = '0;
    unique case (1'b1)
      (bus.wb_sel == 2'b00): w_wb_data = bus.alu_out;
      (bus.wb_sel == 2'b01): w_wb_data = bus.imm;
      (bus.wb_sel == 2'b10): w_wb_data = bus.pc + XLEN'(4);
      default:               w_wb_data = '0;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pend_rd_nxt = r_pend_rd;
    unique case (r_state)
      S_IDLE: begin
        if (w_ld_ok) begin
          w_state_nxt   = S_WAIT;
          w_pend_rd_nxt = bus.rd;
        end
      end
      S_WAIT: begin
        if (bus.dmem_rvalid) begin
          w_state_nxt = S_IDLE;
          if (w_ld_ok) begin
            w_state_nxt   = S_WAIT;
            w_pend_rd_nxt = bus.rd;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pend_rd <= 5'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_pend_rd <= w_pend_rd_nxt;
    end
  end

  // The younger we write is placed last so it wins over a same-rd return.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_regs[0] <= '0;
      for (int i = 1; i < 32; i++)
        r_regs[i] <= RESET_VAL;
    end else begin
      if (w_ld_commit)
        r_regs[r_pend_rd] <= bus.dmem_rdata;
      if (w_we_ok)
        r_regs[bus.rd] <= w_wb_data;
    end
  end

  function automatic logic [XLEN-1:0] rd_port(
    input logic [4:0] a
  );
    logic [XLEN-1:0] v;
    v = r_regs[a];
`ifdef RF_LOAD_BYPASS_EN
    if (w_ld_commit && a == r_pend_rd)
      v = bus.dmem_rdata;
`endif
    if (a == 5'd0)
      v = '0;
    return v;
  endfunction

  assign bus.rrdata1      = rd_port(bus.rs1);
  assign bus.rrdata2      = rd_port(bus.rs2);
  assign bus.load_pending = w_pend;
  assign bus.stall        = w_stall;

endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench for regfile_wb.
// Expected values are queued on stimulus and popped at observation.
module tb_regfile_wb;
  localparam int          XLEN = 32;
  localparam logic [31:0] RV   = 32'h0;

`ifdef RF_LOAD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_if #(.XLEN(XLEN)) bus ();

  regfile_wb #(
    .XLEN(XLEN),
    .RESET_VAL(RV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int          n_chk = 0;
  int          n_err = 0;
  string       q_tag [$];
  logic [31:0] q_exp [$];

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h",
        tag, obs, exp);
    end
  endtask

  task automatic sb_push(
    input string tag,
    input logic [31:0] exp
  );
    q_tag.push_back(tag);
    q_exp.push_back(exp);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    if (q_exp.size() == 0)
      chk("sb_empty", obs, 32'hxxxx_xxxx);
    else
      chk(q_tag.pop_front(), obs, q_exp.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rs1         = '0;
    bus.rs2         = '0;
    bus.rd          = '0;
    bus.we          = 1'b0;
    bus.wb_sel      = 2'b00;
    bus.alu_out     = '0;
    bus.imm         = '0;
    bus.pc          = '0;
    bus.load_issue  = 1'b0;
    bus.dmem_rdata  = '0;
    bus.dmem_rvalid = 1'b0;
  endtask

  task automatic wr(
    input logic [4:0]  a,
    input logic [1:0]  sel,
    input logic [31:0] v
  );
    bus.we      = 1'b1;
    bus.rd      = a;
    bus.wb_sel  = sel;
    bus.alu_out = v;
    bus.imm     = v;
    bus.pc      = v;
    tick();
    bus.we = 1'b0;
    bus.rd = '0;
  endtask

  task automatic rd_chk(
    input string tag,
    input logic [4:0] a,
    input logic [31:0] exp
  );
    sb_push(tag, exp);
    bus.rs1 = a;
    bus.rs2 = '0;
    #1;
    sb_pop(bus.rrdata1);
    bus.rs1 = '0;
  endtask

  task automatic issue(input logic [4:0] a);
    bus.load_issue = 1'b1;
    bus.rd         = a;
    tick();
    bus.load_issue = 1'b0;
    bus.rd         = '0;
  endtask

  function automatic logic [31:0] f(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;

    chk("rst_lp", 32'(bus.load_pending), 0);
    chk("rst_stall", 32'(bus.stall), 0);
    for (int i = 0; i < 32; i++) begin
      sb_push("rst_r1", (i == 0) ? 32'h0 : RV);
      sb_push("rst_r2", (i == 0) ? 32'h0 : RV);
      bus.rs1 = 5'(i);
      bus.rs2 = 5'(i);
      #1;
      sb_pop(bus.rrdata1);
      sb_pop(bus.rrdata2);
    end
    bus.rs1 = '0;
    bus.rs2 = '0;

    for (int i = 1; i < 32; i++) begin
      sb_push("wr_alu", f(i));
      wr(5'(i), 2'b00, f(i));
    end
    for (int i = 1; i < 32; i++) begin
      bus.rs2 = 5'(i);
      #1;
      sb_pop(bus.rrdata2);
    end
    bus.rs2 = '0;

    bus.we      = 1'b1;
    bus.rd      = 5'd20;
    bus.alu_out = 32'h2020;
    bus.rs1     = 5'd20;
    #1;
    chk("rdw_old", bus.rrdata1, f(20));
    tick();
    bus.we = 1'b0;
    chk("rdw_new", bus.rrdata1, 32'h2020);

    wr(5'd6, 2'b01, 32'hABCD_0000);
    rd_chk("imm", 5'd6, 32'hABCD_0000);
    wr(5'd8, 2'b11, 32'h0BAD);
    rd_chk("sel11", 5'd8, f(8));
    wr(5'd5, 2'b10, 32'hFFFF_FFFC);
    rd_chk("pc4_wrap", 5'd5, 32'h0);
    wr(5'd13, 2'b10, 32'h100);
    rd_chk("pc4", 5'd13, 32'h104);
    wr(5'd0, 2'b00, 32'hDEAD);
    rd_chk("x0", 5'd0, 32'h0);

    // load-use on x7
    bus.load_issue = 1'b1;
    bus.rd         = 5'd7;
    #1;
    chk("ld_iss_stall", 32'(bus.stall), 0);
    tick();
    bus.load_issue = 1'b0;
    bus.rs1        = 5'd7;
    bus.we         = 1'b1;
    bus.rd         = 5'd10;
    bus.alu_out    = 32'hEEEE;
    #1;
    chk("ld_lp", 32'(bus.load_pending), 1);
    chk("ld_st1", 32'(bus.stall), 1);
    tick();
    bus.we = 1'b0;
    bus.rd = '0;
    chk("ld_st2", 32'(bus.stall), 1);
    tick();
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h1234;
    #1;
    chk("ld_st3", 32'(bus.stall), BYP ? 0 : 1);
    chk("ld_byp", bus.rrdata1,
      BYP ? 32'h1234 : f(7));
    tick();
    bus.dmem_rvalid = 1'b0;
    chk("ld_st4", 32'(bus.stall), 0);
    chk("ld_lp0", 32'(bus.load_pending), 0);
    chk("ld_x7", bus.rrdata1, 32'h1234);
    rd_chk("stall_we", 5'd10, f(10));

    // same-cycle return and write to x3
    issue(5'd3);
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'hAA;
    bus.we          = 1'b1;
    bus.rd          = 5'd3;
    bus.alu_out     = 32'hBB;
    #1;
    chk("ww_stall", 32'(bus.stall), 0);
    tick();
    idle();
    chk("ww_lp", 32'(bus.load_pending), 0);
    rd_chk("ww_x3", 5'd3, 32'hBB);

    // back-to-back load in return cycle
    issue(5'd3);
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'hAA;
    bus.load_issue  = 1'b1;
    bus.rd          = 5'd4;
    #1;
    chk("b2b_stall", 32'(bus.stall), 0);
    tick();
    idle();
    chk("b2b_lp", 32'(bus.load_pending), 1);
    rd_chk("b2b_x3", 5'd3, 32'hAA);
    bus.rs1 = 5'd4;
    #1;
    chk("b2b_hz4", 32'(bus.stall), 1);
    bus.rs1 = 5'd3;
    #1;
    chk("b2b_hz3", 32'(bus.stall), 0);
    bus.rs1         = '0;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h44;
    tick();
    idle();
    rd_chk("b2b_x4", 5'd4, 32'h44);

    // second load waits for the first return
    issue(5'd9);
    bus.load_issue = 1'b1;
    bus.rd         = 5'd11;
    #1;
    chk("ll_stall", 32'(bus.stall), 1);
    tick();
    chk("ll_lp", 32'(bus.load_pending), 1);
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h99;
    #1;
    chk("ll_rel", 32'(bus.stall), 0);
    tick();
    idle();
    chk("ll_lp2", 32'(bus.load_pending), 1);
    rd_chk("ll_x9", 5'd9, 32'h99);
    bus.rs1 = 5'd11;
    #1;
    chk("ll_hz11", 32'(bus.stall), 1);
    bus.rs1         = '0;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h1111;
    tick();
    idle();
    rd_chk("ll_x11", 5'd11, 32'h1111);

    // reset while waiting
    issue(5'd9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h55;
    #1;
    chk("rw_stall", 32'(bus.stall), 0);
    tick();
    idle();
    chk("rw_lp", 32'(bus.load_pending), 0);
    rd_chk("rw_x9", 5'd9, RV);
    rd_chk("rw_x11", 5'd11, RV);
    rd_chk("rw_x4", 5'd4, RV);

    // return while idle
    issue(5'd12);
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h777;
    tick();
    idle();
    rd_chk("idle_x12a", 5'd12, 32'h777);
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h55;
    tick();
    idle();
    chk("idle_lp", 32'(bus.load_pending), 0);
    rd_chk("idle_x12b", 5'd12, 32'h777);

    chk("sb_left", 32'(q_exp.size()), 0);
    $display("Result: errors=%0d of %0d checks",
      n_err, n_chk);
    $finish;
  end

endmodule
